mul_unit: RTL

Iterative multi-cycle multiplier sitting directly downstream of the Controller. It consumes the Controller's `mul_ctl` decode and the register-file operands, and computes MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. It stalls the core via `busy` and returns a 64-bit result plus N/Z flags on a one-cycle `done` pulse.

---
 rtl/mul_unit_pkg.sv | 20 ++
 rtl/mul_unit_cond_negate.sv | 13 +
 rtl/mul_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mul_unit_pkg.sv
// Shared definitions for the iterative multiplier: mul_ctl bit positions,
// the control-state encoding and the fixed iteration count.
package mul_pkg;

  // Bit positions inside mul_ctl
  localparam int MUL_VALID  = 3;
  localparam int MUL_LONG   = 2;
  localparam int MUL_SIGNED = 1;
  localparam int MUL_ACC    = 0;

  // Number of radix-2 steps for a full-width multiplier
  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_unit_cond_negate.sv
// Conditional two's-complement negate: dout = neg ? -din : din.
// Used for operand magnitudes and for restoring the sign of the product.
module cond_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/MLA/UMULL/UMLAL/SMULL/SMLAL.
// Signed long operations are done on magnitudes and the sign is applied in
// the FIX state, followed by the optional accumulate.
// Optional feature: define MUL_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier bits are all zero; otherwise latency is always 33.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mul_ctl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic [1:0]       mul_flags
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(MUL_ITER);

  mul_state_t       state_reg;
  logic             long_reg;
  logic             acc_en_reg;
  logic             neg_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] mb_reg;
  logic [PW-1:0]    ma_reg;
  logic [PW-1:0]    prod_reg;
  logic [CW-1:0]    cnt_reg;

  // Operand magnitudes: only signed long operations take absolute values
  logic             signed_long;
  logic [WIDTH-1:0] op_raw [2];
  logic [WIDTH-1:0] op_mag [2];

  assign signed_long = mul_ctl[MUL_LONG] & mul_ctl[MUL_SIGNED];
  assign op_raw[0]   = src_a;
  assign op_raw[1]   = src_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mag
      cond_negate #(.W(WIDTH)) u_mag (
        .neg  (signed_long & op_raw[gi][WIDTH-1]),
        .din  (op_raw[gi]),
        .dout (op_mag[gi])
      );
    end
  endgenerate

  // One radix-2 step: add the shifted multiplicand when the multiplier LSB is set
  logic [PW-1:0] prod_step;
  assign prod_step = mb_reg[0] ? (prod_reg + ma_reg) : prod_reg;

  // CALC exit: after the last fixed step, or early once no multiplier bits remain
  logic calc_exit;
`ifdef MUL_EARLY_TERM_EN
  assign calc_exit = (cnt_reg == '0) || (mb_reg[WIDTH-1:1] == '0);
`else
  assign calc_exit = (cnt_reg == '0);
`endif

  // Sign restoration of the magnitude product
  logic [PW-1:0] prod_fixed;
  cond_negate #(.W(PW)) u_fix (
    .neg  (neg_reg),
    .din  (prod_reg),
    .dout (prod_fixed)
  );

  // Accumulate and flag generation for the FIX state
  logic [PW-1:0] acc_val;
  logic [PW-1:0] sum_val;
  logic          res_n;
  logic          res_z;

  // Select the accumulate addend and derive N/Z from the written result width
  always_comb begin
    acc_val = '0;
    if (acc_en_reg) begin
      acc_val = long_reg ? {acc_hi_reg, acc_lo_reg} : {{WIDTH{1'b0}}, acc_lo_reg};
    end
    sum_val = prod_fixed + acc_val;
    res_n   = long_reg ? sum_val[PW-1] : sum_val[WIDTH-1];
    res_z   = long_reg ? (sum_val == '0) : (sum_val[WIDTH-1:0] == '0);
  end

  // Control FSM with registered outputs: IDLE -> CALC -> FIX -> IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      long_reg   <= 1'b0;
      acc_en_reg <= 1'b0;
      neg_reg    <= 1'b0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      mb_reg     <= '0;
      ma_reg     <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result_hi  <= '0;
      result_lo  <= '0;
      mul_flags  <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && mul_ctl[MUL_VALID]) begin
            long_reg   <= mul_ctl[MUL_LONG];
            acc_en_reg <= mul_ctl[MUL_ACC];
            neg_reg    <= signed_long & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            acc_hi_reg <= acc_hi;
            acc_lo_reg <= acc_lo;
            ma_reg     <= {{WIDTH{1'b0}}, op_mag[0]};
            mb_reg     <= op_mag[1];
            prod_reg   <= '0;
            cnt_reg    <= CW'(MUL_ITER - 1);
            busy       <= 1'b1;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          prod_reg <= prod_step;
          ma_reg   <= ma_reg << 1;
          mb_reg   <= mb_reg >> 1;
          cnt_reg  <= cnt_reg - CW'(1);
          if (calc_exit) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_hi <= long_reg ? sum_val[PW-1:WIDTH] : '0;
          result_lo <= sum_val[WIDTH-1:0];
          mul_flags <= {res_n, res_z};
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
